// File: rtl/sb_pkg.sv
// Shared types and helpers for the issue scoreboard.
//   REG_W / NREG   : architectural register index width and register count
//   reg_idx_t      : register index
//   busy_vec_t     : one busy bit per architectural register
//   iss_state_t    : issue register occupancy
//   onehot_reg()   : register index -> one-hot busy-vector mask
package sb_pkg;

  localparam int REG_W = 5;
  localparam int NREG  = 32;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [NREG-1:0]  busy_vec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } iss_state_t;

  function automatic busy_vec_t onehot_reg(input reg_idx_t idx);
    busy_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sb_busy_table.sv
// Register busy table for the issue scoreboard.
// Tracks which architectural registers have a write pending, answers the
// hazard lookup for the instruction at the issue input, and reports which
// writeback / flush events actually released a busy register.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   set_en, set_rd      mark set_rd busy (issue of a register writer)
//   wb_valid, wb_rd     writeback; clears wb_rd if busy
//   flush_clr_en/_rd    discard of a held writer; clears its rd
//   lk_*                hazard lookup operands of the incoming instruction
//   haz                 incoming instruction must stall
//   wb_clr              writeback released a busy register
//   wb_spurious         writeback to a register that was not busy
//   flush_clr           flush released a busy register (not already cleared by wb)
//
// Build option: SB_WB_BYPASS_EN lets a same-cycle writeback resolve a hazard.
module sb_busy_table
  import sb_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_rd,
  input  logic     wb_valid,
  input  reg_idx_t wb_rd,
  input  logic     flush_clr_en,
  input  reg_idx_t flush_clr_rd,
  input  logic     lk_uses_rs1,
  input  reg_idx_t lk_rs1,
  input  logic     lk_uses_rs2,
  input  reg_idx_t lk_rs2,
  input  logic     lk_reg_write,
  input  reg_idx_t lk_rd,
  output logic     haz,
  output logic     wb_clr,
  output logic     wb_spurious,
  output logic     flush_clr
);

  busy_vec_t busy_reg;
  busy_vec_t busy_next;
  busy_vec_t busy_eff;

  logic wb_live;

  assign wb_live     = wb_valid && (wb_rd != '0);
  assign wb_clr      = wb_live && busy_reg[wb_rd];
  assign wb_spurious = wb_live && !busy_reg[wb_rd];
  // If writeback already releases the same register this cycle, the flush
  // must not release it a second time or the inflight count would drift.
  assign flush_clr   = flush_clr_en && (flush_clr_rd != '0) && busy_reg[flush_clr_rd]
                       && !(wb_live && (wb_rd == flush_clr_rd));

`ifdef SB_WB_BYPASS_EN
  assign busy_eff = busy_reg & ~(wb_valid ? onehot_reg(wb_rd) : busy_vec_t'(0));
`else
  assign busy_eff = busy_reg;
`endif

  assign haz = (lk_uses_rs1  && (lk_rs1 != '0) && busy_eff[lk_rs1]) ||
               (lk_uses_rs2  && (lk_rs2 != '0) && busy_eff[lk_rs2]) ||
               (lk_reg_write && (lk_rd  != '0) && busy_eff[lk_rd]);

  // Per-register next state. x0 is hardwired idle. A set on the same
  // register as a clear wins, so a re-issued writer stays tracked.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_en && (set_rd == reg_idx_t'(gi));
        assign clr_hit = (wb_valid && (wb_rd == reg_idx_t'(gi))) ||
                         (flush_clr_en && (flush_clr_rd == reg_idx_t'(gi)));
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage between decoder and execute unit. Holds one decoded
// instruction, stalls it on RAW/WAW hazards against pending register writes,
// and caps the number of outstanding register writes at MAX_INFLIGHT.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   io_in_*                       decoded instruction + valid/ready handshake
//   io_out_*                      held instruction + valid/ready handshake to EXU
//   io_wb_valid, io_wb_rd         register writeback
//   io_flush                      discard held instruction (redirect)
//   io_inflight                   outstanding tracked register writes
//   io_err                        sticky: writeback to a non-busy register
//
// Build option: SB_WB_BYPASS_EN (in sb_busy_table) accepts a consumer in the
// same cycle as the writeback that resolves its hazard.
module issue_scoreboard
  import sb_pkg::*;
#(
  parameter int PAYLOAD_W    = 96,
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [REG_W-1:0]     io_in_rs1,
  input  logic [REG_W-1:0]     io_in_rs2,
  input  logic [REG_W-1:0]     io_in_rd,
  input  logic                 io_in_uses_rs1,
  input  logic                 io_in_uses_rs2,
  input  logic                 io_in_reg_write,
  input  logic [PAYLOAD_W-1:0] io_in_payload,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [REG_W-1:0]     io_out_rd,
  output logic                 io_out_reg_write,
  output logic [PAYLOAD_W-1:0] io_out_payload,
  input  logic                 io_wb_valid,
  input  logic [REG_W-1:0]     io_wb_rd,
  input  logic                 io_flush,
  output logic [CNT_W-1:0]     io_inflight,
  output logic                 io_err
);

  iss_state_t state_reg;
  iss_state_t state_next;

  reg_idx_t               out_rd_reg;
  logic                   out_reg_write_reg;
  logic [PAYLOAD_W-1:0]   out_payload_reg;
  logic [CNT_W-1:0]       inflight_reg;
  logic [CNT_W-1:0]       inflight_next;
  logic                   err_reg;

  logic haz;
  logic wb_clr;
  logic wb_spurious;
  logic flush_clr;
  logic full_cnt;
  logic in_writes_reg;
  logic accept;
  logic set_en;
  logic out_valid;

  assign out_valid     = (state_reg == ST_FULL);
  assign in_writes_reg = io_in_reg_write && (io_in_rd != '0);
  // No credit is taken from a same-cycle writeback: the counter is compared
  // as registered.
  assign full_cnt      = (inflight_reg == CNT_W'(MAX_INFLIGHT));

  // Ready never looks at in_valid, so the upstream handshake has no loop.
  assign io_in_ready = (!out_valid || io_out_ready) && !haz &&
                       !(in_writes_reg && full_cnt) && !io_flush;
  assign accept      = io_in_valid && io_in_ready;
  assign set_en      = accept && in_writes_reg;

  sb_busy_table u_busy (
    .clock        (clock),
    .reset        (reset),
    .set_en       (set_en),
    .set_rd       (io_in_rd),
    .wb_valid     (io_wb_valid),
    .wb_rd        (io_wb_rd),
    .flush_clr_en (io_flush && out_valid && out_reg_write_reg),
    .flush_clr_rd (out_rd_reg),
    .lk_uses_rs1  (io_in_uses_rs1),
    .lk_rs1       (io_in_rs1),
    .lk_uses_rs2  (io_in_uses_rs2),
    .lk_rs2       (io_in_rs2),
    .lk_reg_write (io_in_reg_write),
    .lk_rd        (io_in_rd),
    .haz          (haz),
    .wb_clr       (wb_clr),
    .wb_spurious  (wb_spurious),
    .flush_clr    (flush_clr)
  );

  // Issue register occupancy. Flush dominates any same-cycle drain.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) state_next = ST_FULL;
      end
      ST_FULL: begin
        if (io_flush)                   state_next = ST_EMPTY;
        else if (io_out_ready && !accept) state_next = ST_EMPTY;
        else                             state_next = ST_FULL;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // A set and a writeback clear of the same register cancel to zero here,
  // matching the busy bit staying set.
  assign inflight_next = inflight_reg + CNT_W'(set_en) - CNT_W'(wb_clr) - CNT_W'(flush_clr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_EMPTY;
      out_rd_reg        <= '0;
      out_reg_write_reg <= 1'b0;
      out_payload_reg   <= '0;
      inflight_reg      <= '0;
      err_reg           <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      if (accept) begin
        out_rd_reg        <= io_in_rd;
        out_reg_write_reg <= io_in_reg_write;
        out_payload_reg   <= io_in_payload;
      end
      if (wb_spurious) err_reg <= 1'b1;
    end
  end

  assign io_out_valid     = out_valid;
  assign io_out_rd        = out_rd_reg;
  assign io_out_reg_write = out_reg_write_reg;
  assign io_out_payload   = out_payload_reg;
  assign io_inflight      = inflight_reg;
  assign io_err           = err_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (default MAX_INFLIGHT=4, PAYLOAD_W=96).
module tb_issue_scoreboard;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_reg_write;
  logic [95:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [95:0] out_payload;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [2:0]  inflight;
  logic        err;

  int checks   = 0;
  int failures = 0;

  issue_scoreboard dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_valid      (in_valid),
    .io_in_ready      (in_ready),
    .io_in_rs1        (in_rs1),
    .io_in_rs2        (in_rs2),
    .io_in_rd         (in_rd),
    .io_in_uses_rs1   (in_uses_rs1),
    .io_in_uses_rs2   (in_uses_rs2),
    .io_in_reg_write  (in_reg_write),
    .io_in_payload    (in_payload),
    .io_out_valid     (out_valid),
    .io_out_ready     (out_ready),
    .io_out_rd        (out_rd),
    .io_out_reg_write (out_reg_write),
    .io_out_payload   (out_payload),
    .io_wb_valid      (wb_valid),
    .io_wb_rd         (wb_rd),
    .io_flush         (flush),
    .io_inflight      (inflight),
    .io_err           (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic [95:0] pl);
    in_valid = v; in_rs1 = rs1; in_uses_rs1 = u1; in_rs2 = rs2; in_uses_rs2 = u2;
    in_rd = rd; in_reg_write = rw; in_payload = pl;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    wb(0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", dut.u_busy.busy_reg, 0);
    chk("reset_payload", out_payload, 0);

    // 1. independent stream rd=1,2,3
    drive(1, 0, 0, 0, 0, 1, 1, 96'hA1); #1;
    chk("s1_ready_rd1", in_ready, 1);
    tick();
    chk("s1_valid_rd1", out_valid, 1);
    chk("s1_inflight1", inflight, 1);
    chk("s1_payload1", out_payload, 96'hA1);
    drive(1, 0, 0, 0, 0, 2, 1, 96'hA2); #1;
    chk("s1_ready_rd2", in_ready, 1);
    tick();
    chk("s1_out_rd2", out_rd, 2);
    chk("s1_inflight2", inflight, 2);
    drive(1, 0, 0, 0, 0, 3, 1, 96'hA3);
    tick();
    chk("s1_inflight3", inflight, 3);
    chk("s1_busy", dut.u_busy.busy_reg, 32'h0000_000E);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("s1_drained", out_valid, 0);
    wb(1, 1); tick(); wb(1, 2); tick(); wb(1, 3); tick(); wb(0, 0);
    chk("s1_wb_inflight0", inflight, 0);
    chk("s1_wb_err", err, 0);

    // 2. RAW on x5
    drive(1, 0, 0, 0, 0, 5, 1, 96'hB5);
    tick();
    chk("s2_inflight1", inflight, 1);
    drive(1, 5, 1, 0, 0, 5, 1, 96'hB6); #1;
    chk("s2_raw_stall", in_ready, 0);
    tick();
    chk("s2_drained", out_valid, 0);
    chk("s2_still_stall", in_ready, 0);
    wb(1, 5); #1;
`ifdef SB_WB_BYPASS_EN
    chk("s2_wb_cycle_ready", in_ready, 1);
    tick();
    wb(0, 0); drive(0, 0, 0, 0, 0, 0, 0, '0);
`else
    chk("s2_wb_cycle_ready", in_ready, 0);
    tick();
    wb(0, 0); #1;
    chk("s2_after_wb_infl", inflight, 0);
    chk("s2_after_wb_ready", in_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, '0);
`endif
    chk("s2_reissue_valid", out_valid, 1);
    chk("s2_reissue_rd", out_rd, 5);
    chk("s2_reissue_payload", out_payload, 96'hB6);
    chk("s2_reissue_infl", inflight, 1);
    chk("s2_busy5", dut.u_busy.busy_reg, 32'h0000_0020);
    tick();
    wb(1, 5); tick(); wb(0, 0);
    chk("s2_clean", inflight, 0);

    // 3. x0 destination and source
    drive(1, 0, 0, 0, 0, 0, 1, 96'hC0);
    tick();
    chk("s3_x0_valid", out_valid, 1);
    chk("s3_x0_inflight", inflight, 0);
    chk("s3_x0_busy", dut.u_busy.busy_reg, 0);
    drive(1, 0, 1, 0, 1, 0, 0, 96'hC1); #1;
    chk("s3_x0_src_ready", in_ready, 1);
    tick();
    chk("s3_x0_src_payload", out_payload, 96'hC1);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    tick();

    // 4. credit limit
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 1, 96'(i));
      tick();
    end
    chk("s4_inflight4", inflight, 4);
    drive(1, 0, 0, 0, 0, 6, 1, 96'hD6); #1;
    chk("s4_full_stall", in_ready, 0);
    tick();
    chk("s4_still_infl4", inflight, 4);
    wb(1, 1); #1;
    chk("s4_no_same_credit", in_ready, 0);
    tick();
    wb(0, 0); #1;
    chk("s4_infl3", inflight, 3);
    chk("s4_ready_after", in_ready, 1);
    tick();
    chk("s4_fifth_rd", out_rd, 6);
    chk("s4_fifth_infl", inflight, 4);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    tick();
    wb(1, 2); tick(); wb(1, 3); tick(); wb(1, 4); tick(); wb(1, 6); tick(); wb(0, 0);
    chk("s4_clean", inflight, 0);

    // 5. flush of held rd=7
    out_ready = 1'b0;
    drive(1, 0, 0, 0, 0, 7, 1, 96'hE7);
    tick();
    chk("s5_held_infl", inflight, 1);
    drive(1, 0, 0, 0, 0, 8, 1, 96'hE8); #1;
    chk("s5_backpressure", in_ready, 0);
    tick();
    chk("s5_held_rd", out_rd, 7);
    chk("s5_held_payload", out_payload, 96'hE7);
    flush = 1'b1; out_ready = 1'b1; #1;
    chk("s5_flush_ready", in_ready, 0);
    tick();
    flush = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, '0);
    chk("s5_flush_valid", out_valid, 0);
    chk("s5_flush_busy", dut.u_busy.busy_reg, 0);
    chk("s5_flush_infl", inflight, 0);
    chk("s5_flush_err", err, 0);

    // 6. spurious writeback and mid-stream reset
    drive(1, 0, 0, 0, 0, 10, 1, 96'hF0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    tick();
    wb(1, 0); tick();
    chk("s6_wb_x0_err", err, 0);
    chk("s6_wb_x0_infl", inflight, 1);
    wb(1, 9); tick(); wb(0, 0);
    chk("s6_spurious_err", err, 1);
    chk("s6_spurious_infl", inflight, 1);
    chk("s6_spurious_busy", dut.u_busy.busy_reg, 32'h0000_0400);
    tick();
    chk("s6_err_sticky", err, 1);
    out_ready = 1'b0;
    drive(1, 0, 0, 0, 0, 11, 1, 96'hF1);
    tick();
    chk("s6_pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, '0); out_ready = 1'b1;
    chk("s6_rst_valid", out_valid, 0);
    chk("s6_rst_infl", inflight, 0);
    chk("s6_rst_err", err, 0);
    chk("s6_rst_busy", dut.u_busy.busy_reg, 0);
    chk("s6_rst_rd", out_rd, 0);
    chk("s6_rst_payload", out_payload, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
